// File: rtl/btn_step_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : btn_step_conditioner
// Description : Turns a raw, bouncing push button into a clean one-cycle step
//               strobe for the 3-bit sequential example circuits. It also
//               latches the data switch value at each accepted press and
//               keeps a wrapping count of presses for LED display.
// Ports       : cp            - board clock, rising edge active
//               rst_n         - asynchronous active-low reset
//               btn_raw       - raw push button (active-high, asynchronous)
//               sw_raw        - raw data switch x (asynchronous)
//               btn_level     - debounced button level
//               press_pulse   - one-cycle strobe on each accepted press
//               release_pulse - one-cycle strobe on each accepted release
//               x_held        - switch value captured at the last press
//               step_cnt      - wrapping count of accepted presses
// Revision    : 1.0 - initial release
// ============================================================================
module btn_step_conditioner #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int CNT_W           = 21,
    parameter int STEP_W          = 8
) (
    input  logic              cp,
    input  logic              rst_n,
    input  logic              btn_raw,
    input  logic              sw_raw,
    output logic              btn_level,
    output logic              press_pulse,
    output logic              release_pulse,
    output logic              x_held,
    output logic [STEP_W-1:0] step_cnt
);

    // Counter value on the last stable cycle of a debounce window.
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic             r_btn_meta;
    logic             r_btn_s;
    logic             r_sw_meta;
    logic             r_sw_s;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_accept_press;
    logic             w_accept_release;

    // Two-flop synchronizers for both asynchronous inputs.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
            r_sw_meta  <= 1'b0;
            r_sw_s     <= 1'b0;
        end else begin
            r_btn_meta <= btn_raw;
            r_btn_s    <= r_btn_meta;
            r_sw_meta  <= sw_raw;
            r_sw_s     <= r_sw_meta;
        end
    end

    // State and debounce counter registers.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic. The counter only runs in the two wait states and is
    // cleared on every transition, so it never passes C_CNT_LAST.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_accept_press   = 1'b0;
        w_accept_release = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (r_btn_s) begin
                    w_state_next = ST_PRESS_WAIT;
                end
            end
            ST_PRESS_WAIT: begin
                if (!r_btn_s) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_next   = ST_PRESSED;
                    w_cnt_next     = '0;
                    w_accept_press = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_PRESSED: begin
                w_cnt_next = '0;
                if (!r_btn_s) begin
                    w_state_next = ST_RELEASE_WAIT;
                end
            end
            ST_RELEASE_WAIT: begin
                if (r_btn_s) begin
                    // Bounce during release: the level never dropped.
                    w_state_next = ST_PRESSED;
                    w_cnt_next   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_next     = ST_IDLE;
                    w_cnt_next       = '0;
                    w_accept_release = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Registered outputs, updated on the same edge as the accepting transition.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            x_held        <= 1'b0;
            step_cnt      <= '0;
        end else begin
            press_pulse   <= w_accept_press;
            release_pulse <= w_accept_release;
            if (w_accept_press) begin
                btn_level <= 1'b1;
                x_held    <= r_sw_s;
                step_cnt  <= step_cnt + 1'b1;
            end else if (w_accept_release) begin
                btn_level <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
